// File: rtl/scarf_pkg.sv
// Shared SCARF SPI initiator types: FSM states, frame byte indices, idle MOSI fill.
package scarf_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CS_SETUP,
    SHIFT,
    CS_HOLD,
    GAP
  } state_e;

  localparam int B_ID   = 0;
  localparam int B_AHI  = 1;
  localparam int B_ALO  = 2;
  localparam int B_DATA = 3;

  localparam logic [7:0] MOSI_FILL = 8'h00;

endpackage

// File: rtl/scarf_sclk_gen.sv
// SCLK generator: CLK_DIV clk per half-period, rise/fall strobes mark the edge about to happen.
// Disabling freezes both the divider and sclk level, which is how the master stalls the bus.
module scarf_sclk_gen
  import scarf_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_sync,
  input  logic en_i,
  output logic sclk_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic          sclk_q;
  logic          at_end;

  assign at_end = (cnt_q == CW'(CLK_DIV - 1));
  assign rise_o = en_i && at_end && !sclk_q;
  assign fall_o = en_i && at_end && sclk_q;
  assign sclk_o = sclk_q;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      cnt_q  <= '0;
      sclk_q <= 1'b0;
    end else if (en_i) begin
      if (at_end) begin
        cnt_q  <= '0;
        sclk_q <= ~sclk_q;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/scarf_spi_master.sv
// SCARF SPI initiator (mode 0, MSB first): serialises {rnw,id}, addr_hi, addr_lo, then cmd_len+1 data bytes.
// Define SCARF_ID_CHECK_EN to compare the slave id echo (miso during addr_hi) and flag id_error.
module scarf_spi_master
  import scarf_pkg::*;
#(
  parameter int CLK_DIV  = 4,
  parameter int LEN_W    = 8,
  parameter int CS_GUARD = 2
) (
  input  logic             clk,
  input  logic             rst_sync,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_rnw,
  input  logic [6:0]       cmd_slave_id,
  input  logic [15:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_valid,
  output logic             wr_ready,
  output logic [7:0]       rd_data,
  output logic             rd_valid,
  output logic             done,
  output logic             id_error,
  output logic             sclk,
  output logic             mosi,
  input  logic             miso,
  output logic             cs_n
);

  localparam int BW = LEN_W + 2;
  localparam int GW = $clog2(CS_GUARD + 1);

  state_e           state_q;
  logic             rnw_q;
  logic [15:0]      addr_q;
  logic [LEN_W-1:0] len_q;
  logic [BW-1:0]    byte_q;
  logic [3:0]       bit_q;
  logic [7:0]       tx_q;
  logic [6:0]       rx_q;
  logic             pend_q;
  logic [GW-1:0]    guard_q;
  logic             miso_m_q;
  logic             miso_s_q;
  logic             cs_n_q;
  logic             wr_ready_q;
  logic             rd_valid_q;
  logic [7:0]       rd_data_q;
  logic             done_q;

  logic             sclk_en;
  logic             rise;
  logic             fall;
  logic [BW-1:0]    ld_idx;
  logic [BW-1:0]    last_idx;
  logic [7:0]       ld_byte;
  logic [7:0]       rx_byte;
  logic             need_wr;
  logic             can_load;
  logic             guard_end;

  assign sclk_en = (state_q == SHIFT) && !pend_q;

  scarf_sclk_gen #(.CLK_DIV(CLK_DIV)) u_sclk_gen (
    .clk      (clk),
    .rst_sync (rst_sync),
    .en_i     (sclk_en),
    .sclk_o   (sclk),
    .rise_o   (rise),
    .fall_o   (fall)
  );

  // ld_idx is the byte about to enter the shift register: the next one at a byte
  // boundary, or the current one while a write stall is waiting for wr_valid.
  always_comb begin
    ld_idx    = pend_q ? byte_q : byte_q + BW'(1);
    last_idx  = BW'(len_q) + BW'(B_DATA);
    need_wr   = !rnw_q && (ld_idx >= BW'(B_DATA));
    can_load  = !need_wr || wr_valid;
    guard_end = (guard_q == GW'(CS_GUARD - 1));
    rx_byte   = {rx_q, miso_s_q};
    if (ld_idx == BW'(B_AHI)) begin
      ld_byte = addr_q[15:8];
    end else if (ld_idx == BW'(B_ALO)) begin
      ld_byte = addr_q[7:0];
    end else begin
      ld_byte = rnw_q ? MOSI_FILL : wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      state_q    <= IDLE;
      rnw_q      <= 1'b0;
      addr_q     <= '0;
      len_q      <= '0;
      byte_q     <= '0;
      bit_q      <= '0;
      tx_q       <= MOSI_FILL;
      rx_q       <= '0;
      pend_q     <= 1'b0;
      guard_q    <= '0;
      miso_m_q   <= 1'b0;
      miso_s_q   <= 1'b0;
      cs_n_q     <= 1'b1;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      done_q     <= 1'b0;
    end else begin
      miso_m_q   <= miso;
      miso_s_q   <= miso_m_q;
      wr_ready_q <= 1'b0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          if (cmd_valid) begin
            rnw_q   <= cmd_rnw;
            addr_q  <= cmd_addr;
            len_q   <= cmd_len;
            tx_q    <= {cmd_rnw, cmd_slave_id};
            byte_q  <= BW'(B_ID);
            bit_q   <= '0;
            pend_q  <= 1'b0;
            guard_q <= '0;
            cs_n_q  <= 1'b0;
            state_q <= CS_SETUP;
          end
        end
        CS_SETUP: begin
          if (guard_end) begin
            guard_q <= '0;
            state_q <= SHIFT;
          end else begin
            guard_q <= guard_q + GW'(1);
          end
        end
        SHIFT: begin
          if (pend_q) begin
            if (can_load) begin
              tx_q       <= ld_byte;
              pend_q     <= 1'b0;
              wr_ready_q <= need_wr;
            end
          end else if (rise) begin
            rx_q  <= rx_byte[6:0];
            bit_q <= bit_q + 4'd1;
            if (bit_q == 4'd7 && rnw_q && byte_q >= BW'(B_DATA)) begin
              rd_valid_q <= 1'b1;
              rd_data_q  <= rx_byte;
            end
          end else if (fall) begin
            if (bit_q != 4'd8) begin
              tx_q <= {tx_q[6:0], 1'b0};
            end else begin
              bit_q <= '0;
              if (byte_q == last_idx) begin
                tx_q    <= MOSI_FILL;
                state_q <= CS_HOLD;
              end else begin
                byte_q <= byte_q + BW'(1);
                if (can_load) begin
                  tx_q       <= ld_byte;
                  wr_ready_q <= need_wr;
                end else begin
                  pend_q <= 1'b1;
                end
              end
            end
          end
        end
        CS_HOLD: begin
          if (guard_end) begin
            guard_q <= '0;
            cs_n_q  <= 1'b1;
            done_q  <= 1'b1;
            state_q <= GAP;
          end else begin
            guard_q <= guard_q + GW'(1);
          end
        end
        GAP: begin
          if (guard_end) begin
            guard_q <= '0;
            state_q <= IDLE;
          end else begin
            guard_q <= guard_q + GW'(1);
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef SCARF_ID_CHECK_EN
  logic [6:0] id_q;
  logic       id_err_q;

  always_ff @(posedge clk) begin
    if (rst_sync) begin
      id_q     <= '0;
      id_err_q <= 1'b0;
    end else if (state_q == IDLE && cmd_valid) begin
      id_q     <= cmd_slave_id;
      id_err_q <= 1'b0;
    end else if (state_q == SHIFT && rise && bit_q == 4'd7 && byte_q == BW'(B_AHI)
                 && rx_byte != {1'b0, id_q}) begin
      id_err_q <= 1'b1;
    end
  end

  assign id_error = id_err_q;
`else
  assign id_error = 1'b0;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign cs_n      = cs_n_q;
  assign mosi      = tx_q[7];
  assign wr_ready  = wr_ready_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign done      = done_q;

endmodule

// File: tb/tb_scarf_spi_master.sv
// Bench for scarf_spi_master: table of frames plus random frames, checked against a byte-level frame model.
module tb_scarf_spi_master;

  localparam int CLK_DIV  = 4;
  localparam int LEN_W    = 8;
  localparam int CS_GUARD = 2;
  localparam int STALL    = 114;
`ifdef SCARF_ID_CHECK_EN
  localparam bit ID_CHK = 1'b1;
`else
  localparam bit ID_CHK = 1'b0;
`endif

  logic             clk;
  logic             rst_sync;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_rnw;
  logic [6:0]       cmd_slave_id;
  logic [15:0]      cmd_addr;
  logic [LEN_W-1:0] cmd_len;
  logic [7:0]       wr_data;
  logic             wr_valid;
  logic             wr_ready;
  logic [7:0]       rd_data;
  logic             rd_valid;
  logic             done;
  logic             id_error;
  logic             sclk;
  logic             mosi;
  logic             miso;
  logic             cs_n;

  scarf_spi_master #(.CLK_DIV(CLK_DIV), .LEN_W(LEN_W), .CS_GUARD(CS_GUARD)) dut (
    .clk          (clk),
    .rst_sync     (rst_sync),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_rnw      (cmd_rnw),
    .cmd_slave_id (cmd_slave_id),
    .cmd_addr     (cmd_addr),
    .cmd_len      (cmd_len),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .rd_data      (rd_data),
    .rd_valid     (rd_valid),
    .done         (done),
    .id_error     (id_error),
    .sclk         (sclk),
    .mosi         (mosi),
    .miso         (miso),
    .cs_n         (cs_n)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit          rnw;
    logic [6:0]  id;
    logic [15:0] addr;
    logic [7:0]  len;
    logic [7:0]  echo;
    int          stall_at;
    int          exp_sclk;
    int          exp_wr;
    int          exp_rd;
    bit          exp_iderr;
    logic [7:0]  exp_b0;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;

  // Stimulus shared with the slave / write-source process.
  logic [7:0] wr_bytes [256];
  logic [7:0] slave_bytes [264];
  int         wr_n = 0;
  int         stall_at = -1;

  // Per-frame observations, cleared when cs_n falls.
  int         rise_cnt = 0, wr_cnt = 0, rd_cnt = 0, done_cnt = 0;
  int         low_run = 0, max_run = 0;
  bit         started = 0;
  int         bitn = 0;
  logic [7:0] acc = 8'h00;
  logic [7:0] mosi_q [$];
  logic [7:0] rd_q [$];
  int         overlap_cnt = 0, sclk_err_cnt = 0;
  logic       mprev_cs = 1'b1, mprev_sclk = 1'b0;

  always @(negedge clk) begin
    mprev_cs   <= cs_n;
    mprev_sclk <= sclk;
    if (done && cmd_ready) overlap_cnt <= overlap_cnt + 1;
    if (cs_n && sclk) sclk_err_cnt <= sclk_err_cnt + 1;
    if (mprev_cs && !cs_n) begin
      rise_cnt <= 0; wr_cnt <= 0; rd_cnt <= 0; done_cnt <= 0;
      low_run <= 0; max_run <= 0; started <= 0; bitn <= 0;
      mosi_q.delete();
      rd_q.delete();
    end else begin
      if (sclk && !mprev_sclk) begin
        rise_cnt <= rise_cnt + 1;
        acc      <= {acc[6:0], mosi};
        bitn     <= (bitn + 1) % 8;
        if (bitn == 7) mosi_q.push_back({acc[6:0], mosi});
        if (started && low_run > max_run) max_run <= low_run;
        low_run <= 0;
        started <= 1;
      end else if (!cs_n && !sclk) begin
        low_run <= low_run + 1;
      end
      if (wr_ready) wr_cnt <= wr_cnt + 1;
      if (rd_valid) begin
        rd_cnt <= rd_cnt + 1;
        rd_q.push_back(rd_data);
      end
      if (done) done_cnt <= done_cnt + 1;
    end
  end

  // Mode-0 slave (shifts on falling SCLK) plus a write-byte source with an optional stall.
  task automatic bfm();
    logic       prev_cs = 1'b1, prev_sclk = 1'b0;
    int         sbit = 0, widx = 0, stall_cnt = 0;
    logic [7:0] sb;
    bit         fstart;
    forever begin
      @(negedge clk);
      fstart = prev_cs && !cs_n;
      if (fstart) begin
        sbit = 0; widx = 0; stall_cnt = 0;
        sb = slave_bytes[0];
        miso = sb[7];
      end else if (!cs_n && prev_sclk && !sclk) begin
        sbit++;
        sb = slave_bytes[(sbit / 8) % 264];
        miso = sb[7 - (sbit % 8)];
      end
      if (!fstart && wr_ready) begin
        widx++;
        if (widx == stall_at) stall_cnt = STALL;
      end
      if (stall_cnt > 0) begin
        stall_cnt--;
        wr_valid = 1'b0;
      end else begin
        wr_valid = (widx < wr_n);
      end
      wr_data   = wr_bytes[widx % 256];
      prev_cs   = cs_n;
      prev_sclk = sclk;
    end
  endtask

  task automatic check(input string name, input longint act, input longint exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic issue(input bit rnw, input logic [6:0] id, input logic [15:0] addr, input logic [7:0] len);
    int n = 0;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_rnw = rnw; cmd_slave_id = id; cmd_addr = addr; cmd_len = len;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_frame(input vec_t v, input int which);
    logic [7:0] exp_m [$];
    int n, bad_m, bad_r, len;
    len = int'(v.len);
    for (int i = 0; i < 256; i++) wr_bytes[i] = 8'($urandom);
    for (int i = 0; i < 264; i++) slave_bytes[i] = 8'($urandom);
    slave_bytes[0] = 8'h00;
    slave_bytes[1] = v.echo;
    slave_bytes[2] = 8'h00;
    if (which == 0) begin
      wr_bytes[0] = 8'hA5; wr_bytes[1] = 8'h5A; wr_bytes[2] = 8'hFF;
    end
    if (which == 1) slave_bytes[3] = 8'h3C;
    wr_n     = v.rnw ? 0 : len + 1;
    stall_at = v.stall_at;
    issue(v.rnw, v.id, v.addr, v.len);
    n = 0;
    while (done_cnt == 0 && n < 25000) begin
      @(negedge clk);
      n++;
    end
    repeat (CS_GUARD + 2) @(negedge clk);

    exp_m.push_back({v.rnw, v.id});
    exp_m.push_back(v.addr[15:8]);
    exp_m.push_back(v.addr[7:0]);
    for (int k = 0; k <= len; k++) exp_m.push_back(v.rnw ? 8'h00 : wr_bytes[k]);

    check("done_pulses", done_cnt, 1);
    check("sclk_rises", rise_cnt, v.exp_sclk);
    check("wr_ready_pulses", wr_cnt, v.exp_wr);
    check("rd_valid_pulses", rd_cnt, v.exp_rd);
    check("id_error", id_error, v.exp_iderr);
    check("mosi_byte_count", mosi_q.size(), exp_m.size());
    if (mosi_q.size() > 0) check("mosi_b0", mosi_q[0], v.exp_b0);
    bad_m = 0;
    for (int i = 0; i < mosi_q.size() && i < exp_m.size(); i++)
      if (mosi_q[i] !== exp_m[i]) bad_m++;
    check("mosi_bytes_bad", bad_m, 0);
    bad_r = 0;
    for (int i = 0; i < rd_q.size(); i++)
      if (rd_q[i] !== slave_bytes[3 + i]) bad_r++;
    check("rd_bytes_bad", bad_r, 0);
    if (v.stall_at >= 0) check("stall_sclk_low_ge50", max_run >= 50, 1);
    else                 check("sclk_low_half", max_run, CLK_DIV);
    if (which == 1 && rd_q.size() > 0) check("rd_data_3c", rd_q[0], 8'h3C);
  endtask

  vec_t tbl [6];
  vec_t r;

  initial begin
    int n;
    rst_sync = 1'b1; cmd_valid = 1'b0; cmd_rnw = 1'b0; cmd_slave_id = '0;
    cmd_addr = '0; cmd_len = '0; wr_data = '0; wr_valid = 1'b0; miso = 1'b0;
    for (int i = 0; i < 256; i++) wr_bytes[i] = 8'h00;
    for (int i = 0; i < 264; i++) slave_bytes[i] = 8'h00;
    repeat (3) @(negedge clk);
    rst_sync = 1'b0;
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_cs_n", cs_n, 1);
    check("rst_wr_ready", wr_ready, 0);
    check("rst_rd_valid", rd_valid, 0);
    check("rst_rd_data", rd_data, 0);
    check("rst_done", done, 0);
    check("rst_id_error", id_error, 0);

    fork
      bfm();
    join_none

    //          rnw   id      addr      len    echo   stall sclk  wr   rd   iderr   b0
    tbl[0] = '{1'b0, 7'h02, 16'h1234, 8'h02, 8'h02, -1,   48,   3,   0,   1'b0,   8'h02};
    tbl[1] = '{1'b1, 7'h02, 16'h0010, 8'h00, 8'h02, -1,   32,   0,   1,   1'b0,   8'h82};
    tbl[2] = '{1'b0, 7'h02, 16'hBEEF, 8'h03, 8'h02,  1,   56,   4,   0,   1'b0,   8'h02};
    tbl[3] = '{1'b1, 7'h02, 16'h0000, 8'h00, 8'h05, -1,   32,   0,   1,   ID_CHK, 8'h82};
    tbl[4] = '{1'b1, 7'h7F, 16'hFFFF, 8'hFF, 8'h7F, -1,   2072, 0,   256, 1'b0,   8'hFF};
    tbl[5] = '{1'b0, 7'h55, 16'h8001, 8'h00, 8'h55, -1,   32,   1,   0,   1'b0,   8'h55};
    for (int i = 0; i < 6; i++) run_frame(tbl[i], i);

    // Reset during byte 2, bit 3 of a write frame.
    wr_n = 4; stall_at = -1;
    issue(1'b0, 7'h02, 16'hCAFE, 8'h03);
    n = 0;
    while (rise_cnt < 19 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_bit", rise_cnt, 19);
    rst_sync = 1'b1;
    @(negedge clk);
    check("abort_cs_n", cs_n, 1);
    check("abort_sclk", sclk, 0);
    check("abort_cmd_ready", cmd_ready, 1);
    check("abort_mosi", mosi, 0);
    rst_sync = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_no_done", done_cnt, 0);
    run_frame(tbl[0], 0);

    for (int i = 0; i < 6; i++) begin
      r.rnw       = 1'($urandom_range(0, 1));
      r.id        = 7'($urandom);
      r.addr      = 16'($urandom);
      r.len       = 8'($urandom_range(0, 12));
      r.echo      = {1'b0, r.id};
      r.stall_at  = -1;
      r.exp_sclk  = 8 * (4 + int'(r.len));
      r.exp_wr    = r.rnw ? 0 : int'(r.len) + 1;
      r.exp_rd    = r.rnw ? int'(r.len) + 1 : 0;
      r.exp_iderr = 1'b0;
      r.exp_b0    = {r.rnw, r.id};
      run_frame(r, 10 + i);
    end

    check("done_with_cmd_ready", overlap_cnt, 0);
    check("sclk_high_cs_n_high", sclk_err_cnt, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
